video_coord_gen: RTL and testbench
==================================

# video_coord_gen

Front-end stage of the CNN video path: converts the raw camera stream (frame/line/pixel strobes plus pixel data) into a registered pixel stream tagged with screen coordinates. It sits directly upstream of the window controller and window buffer. Those stages compare `screen_x`/`screen_y` against the buffer position every cycle, so this block drives an out-of-screen sentinel whenever no valid pixel is present. It also flags malformed frames.

## Interface
- `X_BITWIDTH`, default 9: MSB index of x coordinate (width X_BITWIDTH+1).
- `Y_BITWIDTH`, default 8: MSB index of y coordinate.
- `PIXEL_BITWIDTH`, default 7: MSB index of pixel data.
- `SCREEN_W`, default 640: valid pixels per line.
- `SCREEN_H`, default 480: valid lines per frame.

Ports:
- `clock`  in  1: single clock for the block.
- `reset`  in  1: asynchronous, active-high reset.
- `frame_valid`  in  1: camera frame strobe, high for the whole frame.
- `line_valid`  in  1: camera line strobe, high during active pixels of a line.
- `pixel_valid`  in  1: camera pixel qualifier.
- `pixel_in`  in  PIXEL_BITWIDTH+1: camera pixel data.
- `screen_x`  out  X_BITWIDTH+1: x of `pixel_out`; all-ones when `out_valid`=0.
- `screen_y`  out  Y_BITWIDTH+1: y of `pixel_out`; all-ones when `out_valid`=0.
- `pixel_out`  out  PIXEL_BITWIDTH+1: registered pixel; holds its last value when `out_valid`=0.
- `out_valid`  out  1: `pixel_out` and coordinates are valid this cycle.
- `frame_start`  out  1: one-cycle pulse with pixel (0,0).
- `frame_done`  out  1: one-cycle pulse on the `frame_valid` falling edge while in frame.
- `x_overflow`  out  1: sticky; a line exceeded SCREEN_W pixels.
- `y_overflow`  out  1: sticky; a frame exceeded SCREEN_H lines.

## Operation
- States: SYNC, WAIT_FRAME, FRAME, LINE.
  - SYNC: entered on reset. Moves to WAIT_FRAME once `frame_valid`=0 is sampled, so a frame already in progress at reset is never used.
  - WAIT_FRAME: a rising edge of `frame_valid` (sampled 1, previous 0) moves to FRAME and clears `x_cnt`, `y_cnt`, `x_overflow`, `y_overflow`.
  - FRAME: `line_valid`=1 moves to LINE. If the first LINE cycle also has `pixel_valid`=1, that pixel is accepted.
  - LINE: `line_valid`=0 moves to FRAME; `x_cnt` clears; `y_cnt` increments if at least one pixel was accepted on that line.
  - From FRAME or LINE, `frame_valid`=0 moves to WAIT_FRAME and pulses `frame_done`. This takes priority over a simultaneous line end, and `y_cnt` clears.
- Accepted pixel, when all hold:
  - state is LINE (or FRAME→LINE this cycle);
  - `pixel_valid`=1 and `x_cnt` < SCREEN_W;
  - `y_cnt` < SCREEN_H.
- On an accepted pixel: outputs register `x_cnt`, `y_cnt`, `pixel_in`; `x_cnt` increments.
- Extra pixels on a line (`x_cnt`=SCREEN_W): dropped; set `x_overflow`.
- A line starting with `y_cnt`=SCREEN_H: its pixels are dropped; set `y_overflow`. `y_cnt` saturates at SCREEN_H.
- Ignored inputs:
  - `pixel_valid` with `line_valid`=0;
  - `line_valid` with `frame_valid`=0;
  - everything in SYNC.
- `frame_start` is asserted with the output pixel where `x_cnt`=0 and `y_cnt`=0.
- Counter widths: `x_cnt` is X_BITWIDTH+1 bits; SCREEN_W must be < 2^(X_BITWIDTH+1)-1, so the all-ones sentinel is never a legal coordinate. Same rule for y.

## Timing
- Reset values:
  - `screen_x`, `screen_y`: all-ones;
  - `pixel_out`: 0;
  - `out_valid`, `frame_start`, `frame_done`, `x_overflow`, `y_overflow`: 0;
  - state: SYNC.
- Latency: exactly 1 cycle, from sampling an accepted pixel to `out_valid`=1 with its data and coordinates.
- Throughput: one pixel per cycle; back-to-back pixels produce consecutive x values with no gaps.
- `frame_done` is asserted the cycle after `frame_valid` is sampled low.
- Edge detection uses registered copies of `frame_valid` and `line_valid`; there is no combinational path from inputs to outputs.
- Reset mid-line: all outputs return to reset values asynchronously. After release, the block stays in SYNC until `frame_valid` is seen low.

## Test plan
- Reset released while `frame_valid`=1 mid-frame → no `out_valid` until after the next frame rising edge; first output (0,0) carries `frame_start`=1.
- Frame of 4 lines × 640 pixels, continuous → `screen_x` runs 0..639 each line and `screen_y` runs 0..3, each 1 cycle after input; `frame_done` follows the `frame_valid` fall; `screen_x`/`screen_y` return to 0x3FF/0x1FF between pixels.
- Line of 642 pixels → pixels 640 and 641 are dropped, `x_overflow`=1; the next line starts at x=0 with `y_cnt`+1.
- 481 lines in a frame → line 481 produces no output, `y_overflow`=1; both flags clear on the next frame start.
- `pixel_valid` gapped (every other cycle) plus `pixel_valid` pulses with `line_valid`=0 → x increments only on accepted pixels; stray pulses produce no output.
- `line_valid` and `frame_valid` fall in the same cycle → single `frame_done` pulse; the next frame restarts at (0,0).

Source files
------------

// File: rtl/video_coord_gen.sv
// ---------------------------------------------------------------------------
// video_coord_gen
//
// Front end of the CNN video path. Turns the raw camera strobes
// (frame_valid / line_valid / pixel_valid) plus pixel data into a registered
// pixel stream tagged with screen coordinates.
//
// Whenever no valid pixel is present, the coordinate outputs carry an
// all-ones sentinel. This keeps downstream window logic from matching a
// stale position. Malformed frames (lines that are too long, or frames with
// too many lines) raise sticky overflow flags. These flags clear at the next
// frame start.
//
// Ports
//   clock, reset     : single clock, asynchronous active-high reset
//   frame_valid      : camera frame strobe (high for the whole frame)
//   line_valid       : camera line strobe (high during active pixels)
//   pixel_valid      : camera pixel qualifier
//   pixel_in         : camera pixel data
//   screen_x/_y      : coordinates of pixel_out, all-ones when not valid
//   pixel_out        : registered pixel, holds its value when not valid
//   out_valid        : pixel_out and coordinates are valid this cycle
//   frame_start      : one-cycle pulse together with pixel (0,0)
//   frame_done       : one-cycle pulse after frame_valid falls inside a frame
//   x_overflow       : sticky, a line carried more than SCREEN_W pixels
//   y_overflow       : sticky, a frame carried more than SCREEN_H lines
// ---------------------------------------------------------------------------
module video_coord_gen #(
  parameter int X_BITWIDTH     = 9,
  parameter int Y_BITWIDTH     = 8,
  parameter int PIXEL_BITWIDTH = 7,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_valid,
  input  logic                    line_valid,
  input  logic                    pixel_valid,
  input  logic [PIXEL_BITWIDTH:0] pixel_in,
  output logic [X_BITWIDTH:0]     screen_x,
  output logic [Y_BITWIDTH:0]     screen_y,
  output logic [PIXEL_BITWIDTH:0] pixel_out,
  output logic                    out_valid,
  output logic                    frame_start,
  output logic                    frame_done,
  output logic                    x_overflow,
  output logic                    y_overflow
);

  localparam int XW = X_BITWIDTH + 1;
  localparam int YW = Y_BITWIDTH + 1;
  localparam int PW = PIXEL_BITWIDTH + 1;

  localparam logic [XW-1:0] X_LIMIT = XW'(SCREEN_W);
  localparam logic [YW-1:0] Y_LIMIT = YW'(SCREEN_H);

  typedef enum logic [1:0] {
    SYNC       = 2'd0,
    WAIT_FRAME = 2'd1,
    FRAME      = 2'd2,
    LINE       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_cnt_q, x_cnt_d;
  logic [YW-1:0]   y_cnt_q, y_cnt_d;
  logic            line_acc_q, line_acc_d;   // a pixel was accepted on this line
  logic            fv_q;                     // previous frame_valid, for edge detect

  logic [XW-1:0]   screen_x_q, screen_x_d;
  logic [YW-1:0]   screen_y_q, screen_y_d;
  logic [PW-1:0]   pixel_out_q, pixel_out_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            x_ovf_q, x_ovf_d;
  logic            y_ovf_q, y_ovf_d;

  logic            in_line_s;   // LINE this cycle, including the FRAME->LINE entry cycle
  logic            accept_s;

  // Next-state, counter and output computation
  always_comb begin
    state_d       = state_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    line_acc_d    = line_acc_q;
    x_ovf_d       = x_ovf_q;
    y_ovf_d       = y_ovf_q;
    frame_done_d  = 1'b0;
    in_line_s     = 1'b0;
    accept_s      = 1'b0;

    case (state_q)
      SYNC: begin
        // Wait for a gap, so a frame already in flight at reset is never used.
        if (!frame_valid) begin
          state_d = WAIT_FRAME;
        end else begin
          state_d = SYNC;
        end
      end
      WAIT_FRAME: begin
        if (frame_valid && !fv_q) begin
          state_d    = FRAME;
          x_cnt_d    = '0;
          y_cnt_d    = '0;
          line_acc_d = 1'b0;
          x_ovf_d    = 1'b0;
          y_ovf_d    = 1'b0;
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      FRAME: begin
        if (!frame_valid) begin
          state_d      = WAIT_FRAME;
          frame_done_d = 1'b1;
          x_cnt_d      = '0;
          y_cnt_d      = '0;
        end else if (line_valid) begin
          state_d    = LINE;
          in_line_s  = 1'b1;
          line_acc_d = 1'b0;
          // A line beginning after the last legal line is dropped entirely.
          if (y_cnt_q == Y_LIMIT) begin
            y_ovf_d = 1'b1;
          end else begin
            y_ovf_d = y_ovf_q;
          end
        end else begin
          state_d = FRAME;
        end
      end
      LINE: begin
        // A frame end takes priority over a simultaneous line end.
        if (!frame_valid) begin
          state_d      = WAIT_FRAME;
          frame_done_d = 1'b1;
          x_cnt_d      = '0;
          y_cnt_d      = '0;
        end else if (!line_valid) begin
          state_d = FRAME;
          x_cnt_d = '0;
          if (line_acc_q && (y_cnt_q < Y_LIMIT)) begin
            y_cnt_d = y_cnt_q + YW'(1);
          end else begin
            y_cnt_d = y_cnt_q;
          end
        end else begin
          state_d   = LINE;
          in_line_s = 1'b1;
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    // Pixel acceptance. The y check also covers lines dropped for y overflow.
    if (in_line_s && pixel_valid && (y_cnt_q < Y_LIMIT)) begin
      if (x_cnt_q < X_LIMIT) begin
        accept_s   = 1'b1;
        x_cnt_d    = x_cnt_q + XW'(1);
        line_acc_d = 1'b1;
      end else begin
        x_ovf_d = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end

    out_valid_d   = accept_s;
    frame_start_d = accept_s && (x_cnt_q == '0) && (y_cnt_q == '0);
    if (accept_s) begin
      screen_x_d  = x_cnt_q;
      screen_y_d  = y_cnt_q;
      pixel_out_d = pixel_in;
    end else begin
      screen_x_d  = '1;
      screen_y_d  = '1;
      pixel_out_d = pixel_out_q;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SYNC;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      line_acc_q    <= 1'b0;
      fv_q          <= 1'b0;
      screen_x_q    <= '1;
      screen_y_q    <= '1;
      pixel_out_q   <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      x_ovf_q       <= 1'b0;
      y_ovf_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_acc_q    <= line_acc_d;
      fv_q          <= frame_valid;
      screen_x_q    <= screen_x_d;
      screen_y_q    <= screen_y_d;
      pixel_out_q   <= pixel_out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      x_ovf_q       <= x_ovf_d;
      y_ovf_q       <= y_ovf_d;
    end
  end

  assign screen_x    = screen_x_q;
  assign screen_y    = screen_y_q;
  assign pixel_out   = pixel_out_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign x_overflow  = x_ovf_q;
  assign y_overflow  = y_ovf_q;

endmodule

// File: tb/tb_video_coord_gen.sv
module tb_video_coord_gen;

  logic       clock;
  logic       reset;
  logic       frame_valid;
  logic       line_valid;
  logic       pixel_valid;
  logic [7:0] pixel_in;
  logic [9:0] screen_x;
  logic [8:0] screen_y;
  logic [7:0] pixel_out;
  logic       out_valid;
  logic       frame_start;
  logic       frame_done;
  logic       x_overflow;
  logic       y_overflow;

  int n_checks;
  int n_fail;

  video_coord_gen dut (
    .clock       (clock),
    .reset       (reset),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .screen_x    (screen_x),
    .screen_y    (screen_y),
    .pixel_out   (pixel_out),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .x_overflow  (x_overflow),
    .y_overflow  (y_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; return 1 time unit after the sampling edge.
  task automatic drive(input logic fv, input logic lv, input logic pv, input logic [7:0] pix);
    frame_valid = fv;
    line_valid  = lv;
    pixel_valid = pv;
    pixel_in    = pix;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = 8'h00;
    @(posedge clock);
    #1;

    // Reset values
    check("rst_x",   screen_x,    32'h3FF);
    check("rst_y",   screen_y,    32'h1FF);
    check("rst_pix", pixel_out,   32'h0);
    check("rst_ov",  out_valid,   32'h0);
    check("rst_fs",  frame_start, 32'h0);
    check("rst_fd",  frame_done,  32'h0);
    check("rst_xo",  x_overflow,  32'h0);
    check("rst_yo",  y_overflow,  32'h0);

    // Release reset in the middle of a frame: it must be ignored.
    frame_valid = 1'b1;
    line_valid  = 1'b1;
    pixel_valid = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'(i));
      check("sync_ov", out_valid, 32'h0);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("sync_ov2", out_valid, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("sync_fd", frame_done, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    check("first_ov",  out_valid,   32'h1);
    check("first_x",   screen_x,    32'h0);
    check("first_y",   screen_y,    32'h0);
    check("first_pix", pixel_out,   32'h55);
    check("first_fs",  frame_start, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("gap_x", screen_x, 32'h3FF);
    check("gap_y", screen_y, 32'h1FF);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("fd_pulse", frame_done, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("fd_clear", frame_done, 32'h0);

    // Frame of 4 lines x 640 continuous pixels
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 640; i++) begin
        drive(1'b1, 1'b1, 1'b1, 8'(i + l));
        check("f4_ov",  out_valid, 32'h1);
        check("f4_x",   screen_x,  32'(i));
        check("f4_y",   screen_y,  32'(l));
        check("f4_pix", pixel_out, 32'((i + l) % 256));
        check("f4_fs",  frame_start, ((i == 0) && (l == 0)) ? 32'h1 : 32'h0);
      end
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      check("f4_gap_ov", out_valid, 32'h0);
      check("f4_gap_x",  screen_x,  32'h3FF);
      check("f4_gap_y",  screen_y,  32'h1FF);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
    check("f4_xo", x_overflow, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("f4_fd", frame_done, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("f4_fd_clr", frame_done, 32'h0);

    // Line of 642 pixels: last two dropped, x_overflow set
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 642; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'(i));
      check("xo_ov", out_valid, (i < 640) ? 32'h1 : 32'h0);
      if (i == 639) begin
        check("xo_x639", screen_x,   32'd639);
        check("xo_flag0", x_overflow, 32'h0);
      end else if (i == 640) begin
        check("xo_flag1", x_overflow, 32'h1);
        check("xo_x_sent", screen_x,  32'h3FF);
      end else begin
        n_checks = n_checks;
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h11);
    check("xo_next_x", screen_x, 32'h0);
    check("xo_next_y", screen_y, 32'h1);
    drive(1'b1, 1'b1, 1'b1, 8'h12);
    check("xo_next_x1", screen_x, 32'h1);
    check("xo_sticky", x_overflow, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // 481 lines: line 481 dropped, y_overflow set; flags clear on next frame
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("xo_cleared", x_overflow, 32'h0);
    for (int l = 0; l < 480; l++) begin
      drive(1'b1, 1'b1, 1'b1, 8'(l));
      check("yo_ov", out_valid, 32'h1);
      check("yo_y",  screen_y,  32'(l));
      check("yo_x",  screen_x,  32'h0);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
    end
    check("yo_flag0", y_overflow, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 8'hEE);
    check("yo_drop_ov", out_valid,  32'h0);
    check("yo_flag1",   y_overflow, 32'h1);
    drive(1'b1, 1'b1, 1'b1, 8'hEF);
    check("yo_drop_ov2", out_valid, 32'h0);
    check("yo_xo", x_overflow, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("yo_cleared", y_overflow, 32'h0);

    // Gapped pixel_valid, then stray pixel_valid with line_valid low
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, (i % 2) == 0, 8'(8'h40 + i));
      if ((i % 2) == 0) begin
        check("gap_ov", out_valid, 32'h1);
        check("gap_xv", screen_x,  32'(i / 2));
      end else begin
        check("gap_ov0", out_valid, 32'h0);
        check("gap_xs",  screen_x,  32'h3FF);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("hold_pix", pixel_out, 32'h46);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h99);
      check("stray_ov", out_valid, 32'h0);
    end
    drive(1'b1, 1'b1, 1'b1, 8'h77);
    check("after_stray_x", screen_x, 32'h0);
    check("after_stray_y", screen_y, 32'h1);

    // line_valid and frame_valid fall together
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("both_fd", frame_done, 32'h1);
    check("both_ov", out_valid,  32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("both_fd_clr", frame_done, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'hA5);
    check("restart_x",  screen_x,    32'h0);
    check("restart_y",  screen_y,    32'h0);
    check("restart_fs", frame_start, 32'h1);
    check("restart_px", pixel_out,   32'hA5);

    // Asynchronous reset mid-line
    drive(1'b1, 1'b1, 1'b1, 8'hA6);
    check("pre_rst_x", screen_x, 32'h1);
    reset = 1'b1;
    #1;
    check("arst_ov",  out_valid, 32'h0);
    check("arst_x",   screen_x,  32'h3FF);
    check("arst_y",   screen_y,  32'h1FF);
    check("arst_pix", pixel_out, 32'h0);
    #3;
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'hA7);
    check("arst_sync_ov", out_valid, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
